// File: rtl/id_scan_pkg.sv
// Shared encodings, ASCII bounds and the character classifier used by the
// identifier scan controller and its recognizer core.
package id_scan_pkg;

  // Controller states.
  localparam logic [1:0] CTRL_IDLE  = 2'd0;
  localparam logic [1:0] CTRL_FETCH = 2'd1;
  localparam logic [1:0] CTRL_DRAIN = 2'd2;
  localparam logic [1:0] CTRL_DONE  = 2'd3;

  // Recognizer states: S0 = nothing useful seen, S1 = inside a letter run,
  // S2 = inside a digit run that followed a letter run.
  localparam logic [1:0] REC_S0 = 2'd0;
  localparam logic [1:0] REC_S1 = 2'd1;
  localparam logic [1:0] REC_S2 = 2'd2;

  // ASCII range bounds (inclusive).
  localparam logic [7:0] ASCII_UPPER_LO = 8'd65;   // 'A'
  localparam logic [7:0] ASCII_UPPER_HI = 8'd90;   // 'Z'
  localparam logic [7:0] ASCII_LOWER_LO = 8'd97;   // 'a'
  localparam logic [7:0] ASCII_LOWER_HI = 8'd122;  // 'z'
  localparam logic [7:0] ASCII_DIGIT_LO = 8'd48;   // '0'
  localparam logic [7:0] ASCII_DIGIT_HI = 8'd57;   // '9'

  // Character classes: letter, digit, other.
  typedef enum logic [1:0] {
    CLS_L = 2'd0,
    CLS_D = 2'd1,
    CLS_O = 2'd2
  } char_class_e;

  // Classify one byte into letter / digit / other.
  function automatic char_class_e char_class(input logic [7:0] c);
    char_class_e cls;
    cls = CLS_O;
    if (((c >= ASCII_UPPER_LO) && (c <= ASCII_UPPER_HI)) ||
        ((c >= ASCII_LOWER_LO) && (c <= ASCII_LOWER_HI))) begin
      cls = CLS_L;
    end else if ((c >= ASCII_DIGIT_LO) && (c <= ASCII_DIGIT_HI)) begin
      cls = CLS_D;
    end
    return cls;
  endfunction

endpackage

// File: rtl/id_match_core.sv
// Identifier recognizer: advances one character per asserted step and flags
// a hit on the first digit that directly follows a run of letters.
module id_match_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] char,
  output logic       hit,
  output logic [1:0] st
);
  import id_scan_pkg::*;

  logic [1:0]  r_st;
  logic [1:0]  w_st_nxt;
  char_class_e w_cls;

  // Next-state function for the current character.
  always_comb begin
    w_cls    = char_class(char);
    w_st_nxt = r_st;
    case (r_st)
      REC_S0: w_st_nxt = (w_cls == CLS_L) ? REC_S1 : REC_S0;
      REC_S1: begin
        if (w_cls == CLS_L)      w_st_nxt = REC_S1;
        else if (w_cls == CLS_D) w_st_nxt = REC_S2;
        else                     w_st_nxt = REC_S0;
      end
      REC_S2: begin
        if (w_cls == CLS_D)      w_st_nxt = REC_S2;
        else if (w_cls == CLS_L) w_st_nxt = REC_S1;
        else                     w_st_nxt = REC_S0;
      end
      default: w_st_nxt = REC_S0;
    endcase
  end

  // State register; clear wins over step so a new scan never inherits state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= REC_S0;
    end else if (clr) begin
      r_st <= REC_S0;
    end else if (step) begin
      r_st <= w_st_nxt;
    end
  end

  assign hit = step && (r_st == REC_S1) && (w_cls == CLS_D);
  assign st  = r_st;

endmodule

// File: rtl/id_scan_ctrl.sv
// Scan controller: streams `length` characters from a synchronous-read
// memory starting at `base_addr`, steps the recognizer once per returned
// character, and reports match count / first match position with a done
// pulse.
//
// Control interface: start and abort are level-sampled commands, not a
// valid/ready pair. start is taken only in IDLE and only when abort is low;
// abort is honoured only while busy (FETCH or DRAIN). Memory side: mem_en
// is a read strobe and mem_rdata is consumed exactly one cycle later with
// no back-pressure.
module id_scan_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              found,
  output logic [LEN_W-1:0]  first_end,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_rec_st
);
  import id_scan_pkg::*;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [LEN_W-1:0]  r_left;       // issues still owed after the current one
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_pend;       // mem_rdata carries a character this cycle
  logic [LEN_W-1:0]  r_cons_idx;   // index of the character being consumed
  logic [CNT_W-1:0]  r_match_cnt;
  logic              r_found;
  logic [LEN_W-1:0]  r_first_end;

  logic w_busy;
  logic w_start_acc;
  logic w_abort_acc;
  logic w_last_issue;
  logic w_hit;
  logic [1:0] w_rec_st;

  assign w_busy       = (r_state == CTRL_FETCH) || (r_state == CTRL_DRAIN);
  assign w_start_acc  = (r_state == CTRL_IDLE) && start && !abort;
  assign w_abort_acc  = w_busy && abort;
  assign w_last_issue = (r_state == CTRL_FETCH) && (r_left == '0);

  id_match_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_acc),
    .step  (r_pend),
    .char  (mem_rdata),
    .hit   (w_hit),
    .st    (w_rec_st)
  );

  // Controller next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CTRL_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = (length == '0) ? CTRL_DONE : CTRL_FETCH;
        end
      end
      CTRL_FETCH: begin
        if (abort)             w_state_nxt = CTRL_IDLE;
        else if (w_last_issue) w_state_nxt = CTRL_DRAIN;
      end
      CTRL_DRAIN: w_state_nxt = abort ? CTRL_IDLE : CTRL_DONE;
      CTRL_DONE:  w_state_nxt = CTRL_IDLE;
      default:    w_state_nxt = CTRL_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CTRL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read issue: first address loaded at start, then one increment per cycle
  // until the last index has been issued or the scan is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_left     <= '0;
    end else if (w_start_acc) begin
      r_mem_en   <= (length != '0);
      r_mem_addr <= base_addr;
      r_left     <= length - LEN_W'(1);
    end else if (r_state == CTRL_FETCH) begin
      if (abort || w_last_issue) begin
        r_mem_en <= 1'b0;
      end else begin
        r_mem_addr <= r_mem_addr + ADDR_W'(1);
        r_left     <= r_left - LEN_W'(1);
      end
    end else begin
      r_mem_en <= 1'b0;
    end
  end

  // Data-return tracker; an abort drops the character still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_mem_en && !w_abort_acc;
    end
  end

  // Result accumulation: cleared at an accepted start, updated per consumed
  // character, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cons_idx  <= '0;
      r_match_cnt <= '0;
      r_found     <= 1'b0;
      r_first_end <= '0;
    end else if (w_start_acc) begin
      r_cons_idx  <= '0;
      r_match_cnt <= '0;
      r_found     <= 1'b0;
      r_first_end <= '0;
    end else if (r_pend) begin
      r_cons_idx <= r_cons_idx + LEN_W'(1);
      if (w_hit) begin
        if (r_match_cnt != {CNT_W{1'b1}}) begin
          r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
        if (!r_found) begin
          r_found     <= 1'b1;
          r_first_end <= r_cons_idx;
        end
      end
    end
  end

  assign busy       = w_busy;
  assign done       = (r_state == CTRL_DONE);
  assign mem_en     = r_mem_en;
  assign mem_addr   = r_mem_addr;
  assign match_cnt  = r_match_cnt;
  assign found      = r_found;
  assign first_end  = r_first_end;
  assign dbg_state  = r_state;
  assign dbg_rec_st = w_rec_st;

endmodule

// File: doc/id_scan_ctrl.md
Name: id_scan_ctrl

Overview:
- Scan controller that sequences an identifier-recognizer datapath over a byte string held in a synchronous-read memory.
- On `start` it fetches `length` characters from `base_addr` upward, one per cycle, and steps the recognizer once per character.
- It counts identifier matches and reports the count and the position of the first match, with a `done` pulse.
- Sits between a command source (CPU-side register block) and a shared character memory.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 8, width of `length` and `first_end`.
- CNT_W, 8, width of `match_cnt`; the counter saturates.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a scan; sampled in IDLE only.
- abort  in  1  terminate the current scan.
- base_addr  in  ADDR_W  address of the first character, latched at start.
- length  in  LEN_W  number of characters, latched at start.
- busy  out  1  high while in FETCH or DRAIN.
- done  out  1  one-cycle pulse when the scan completes normally.
- mem_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  8  character; valid one cycle after mem_en.
- match_cnt  out  CNT_W  number of matches in the last scan.
- found  out  1  at least one match occurred.
- first_end  out  LEN_W  0-based index of the character that completed the first match; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state IDLE, recognizer S0; busy, done, mem_en, found all 0; mem_addr, match_cnt, first_end all 0.
- Character classes:
  - L = 'A'..'Z' (65–90) or 'a'..'z' (97–122).
  - D = '0'..'9' (48–57).
  - O = anything else.
- Recognizer (id_match_core) steps only when `step`=1. States and transitions:
  - S0: L->S1; D or O->S0.
  - S1: L->S1; D->S2; O->S0.
  - S2: D->S2; L->S1; O->S0.
  - `hit` (combinational) = step and state S1 and char in D. This is the match event: a letter run followed by its first digit.
  - Synchronous `clr` forces S0 and has priority over step.
- Controller FSM:
  - IDLE: on start=1, latch base_addr and length, clear recognizer, match_cnt, found and first_end.
    - If length=0, go to DONE.
    - Otherwise go to FETCH with issue index i=0.
  - FETCH: each cycle mem_en=1, mem_addr=base+i (wrapping), i++. After issuing index length-1, go to DRAIN.
  - Consumption: in every cycle following a mem_en cycle, recognizer step=1 with char=mem_rdata, and consume index j increments.
  - DRAIN: a single cycle that consumes the last character, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Timing: start at cycle 0 with length=L>0 gives:
  - mem_en in cycles 1..L.
  - consumption in cycles 2..L+1.
  - busy in cycles 1..L+1.
  - done in cycle L+2.
  - With L=0, done is in cycle 1 and busy never asserts.
- On hit: match_cnt increments, saturating at 2^CNT_W-1. If found=0, set found=1 and first_end=j.
- Results hold from done until the next accepted start.
- start while busy or in DONE: ignored.
- abort while busy:
  - Next state is IDLE and mem_en drops the next cycle.
  - A pending in-flight character is discarded (no step).
  - done is not pulsed; partial results remain visible.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins, and start is ignored.
- Reset asserted mid-scan: immediate return to reset values, with no done pulse.

Decomposition:
- Package id_scan_pkg holds:
  - controller state encoding (IDLE, FETCH, DRAIN, DONE);
  - recognizer state encoding (S0, S1, S2);
  - ASCII bound constants (65, 90, 97, 122, 48, 57);
  - a char-class function returning L/D/O.
- One sub-module, id_match_core: the recognizer with ports clk, rst_n, clr, step, char[7:0], hit, st[1:0].

Test Plan:
- String "a1b2" at base 0x10, length 4 -> mem_en in cycles 1–4 at addresses 0x10..0x13; done in cycle 6; match_cnt=2; found=1; first_end=1.
- "9ab_c" (length 5) -> no digit follows a letter run; done in cycle 7; match_cnt=0; found=0; first_end=0.
- base 0xFE, length 3, "x12" -> addresses 0xFE, 0xFF, 0x00; match_cnt=1; first_end=1 (the '2' continues S2 and gives no second hit).
- length=0 -> done in cycle 1; busy stays 0; mem_en stays 0; results cleared.
- "ab12cd3" with abort in cycle 4 -> IDLE in cycle 5; no done pulse; match_cnt=1 (from '1' at index 2); start pulsed during busy is ignored.
- CNT_W=2 with "a1a1a1a1a1" -> match_cnt saturates at 3.
- rst_n low at cycle 3 of any scan -> all outputs return to reset values immediately.
- A new scan after reset completes with correct results, with no carried recognizer state.
